pac_chek_multi: RTL and testbench

- Parametrised successor of the single-frame-length packet checker on the VLC receive path.
- Sits after frame_eof_regen on the i_clk (vl_tx clock) domain and consumes the ps-side stream (val/sof/eof/data).
- Checks every frame against a generated pattern in one of two modes, and measures frame length against the expected value.
- Keeps per-frame and cumulative statistics: good/bad frames, word errors, orphan words, and a sticky error flag readable by software.

---
 rtl/pac_chek_pkg.sv | 33 +++
 rtl/pac_chek_multi_sat_counter.sv | 35 +++
 rtl/pac_chek_multi.sv | 248 ++++++++++++++++++++++++
 tb/tb_pac_chek_multi.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pac_chek_pkg.sv
// -----------------------------------------------------------------------------
// pac_chek_pkg
// Shared definitions for the multi-length packet checker:
//   - pattern mode constants
//   - checker FSM state encoding
//   - indices of the cumulative statistics counters
//   - 16-bit saturating increment used for the frame length
// -----------------------------------------------------------------------------
package pac_chek_pkg;

   // Pattern modes
   localparam int MODE_ABS_INC  = 0;   // sof word must be 0, then +1 per word
   localparam int MODE_SEED_INC = 1;   // sof word is the seed, then +1 per word

   // Checker FSM states
   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_IN_FRAME = 1'b1
   } state_t;

   // Cumulative statistics counter slots
   localparam int STAT_GOOD   = 0;
   localparam int STAT_BAD    = 1;
   localparam int STAT_ERR    = 2;
   localparam int STAT_ORPHAN = 3;
   localparam int STAT_NUM    = 4;

   // Increment that sticks at 16'hFFFF instead of wrapping
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pac_chek_multi_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that saturates at all-ones. Clear has priority over increment.
// Ports:
//   i_clk    clock
//   i_rst_n  async active-low reset
//   i_inc    count one event this cycle
//   i_clr    synchronous clear (wins over i_inc)
//   o_cnt    current count
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/pac_chek_multi.sv
// -----------------------------------------------------------------------------
// pac_chek_multi
// Packet checker for the VLC receive path. Checks each frame of the val/sof/eof
// stream against an incrementing pattern, measures its length against
// FRAME_LEN_VAL and keeps per-frame and cumulative statistics.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_clr                   sync clear of counters, sticky flag, frame results
//   i_pac_chek_data         received word
//   i_pac_chek_data_valid   word valid (checker is always ready)
//   i_pac_chek_sof/eof      first/last word of a frame (qualified by valid)
//   o_good_word_num         matching words of the last completed frame
//   o_last_frame_len        length of the last completed frame (saturating)
//   o_frame_done/o_frame_ok one-cycle result pulses
//   o_good/bad_frame_cnt    cumulative good/bad frames
//   o_err_word_cnt          cumulative mismatched words
//   o_orphan_cnt            valid words seen outside a frame
//   o_err_sticky            set on any bad frame or orphan word
//   o_busy                  a frame is in progress
// -----------------------------------------------------------------------------
module pac_chek_multi
   import pac_chek_pkg::*;
#(
   parameter int          DATA_W        = 32,
   parameter int          CNT_W         = 32,
   parameter logic [15:0] FRAME_LEN_VAL = 16'd200,
   parameter int          PATTERN_MODE  = 0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic [DATA_W-1:0] i_pac_chek_data,
   input  logic              i_pac_chek_data_valid,
   input  logic              i_pac_chek_sof,
   input  logic              i_pac_chek_eof,
   output logic [CNT_W-1:0]  o_good_word_num,
   output logic [15:0]       o_last_frame_len,
   output logic              o_frame_done,
   output logic              o_frame_ok,
   output logic [CNT_W-1:0]  o_good_frame_cnt,
   output logic [CNT_W-1:0]  o_bad_frame_cnt,
   output logic [CNT_W-1:0]  o_err_word_cnt,
   output logic [CNT_W-1:0]  o_orphan_cnt,
   output logic              o_err_sticky,
   output logic              o_busy
);

   state_t              r_state;
   state_t              w_state_next;

   // In-progress frame
   logic [DATA_W-1:0]   r_exp;
   logic [15:0]         r_len;
   logic [CNT_W-1:0]    r_good;
   logic                r_err;

   // Registered frame results
   logic [CNT_W-1:0]    r_good_word_num;
   logic [15:0]         r_last_frame_len;
   logic                r_frame_done;
   logic                r_frame_ok;
   logic                r_err_sticky;

   logic                w_sof_ok;
   logic [CNT_W-1:0]    w_good_inc;
   logic                w_start;
   logic                w_adv;
   logic                w_done;
   logic                w_trunc;
   logic                w_orphan;
   logic                w_word_mis;
   logic [15:0]         w_fin_len;
   logic [CNT_W-1:0]    w_fin_good;
   logic                w_fin_err;
   logic                w_fin_ok;

   logic [STAT_NUM-1:0] w_cnt_inc;
   logic [CNT_W-1:0]    w_cnt [STAT_NUM];

   // The sof word is judged alone: it must be zero in absolute mode and is
   // always good when it seeds the pattern.
   assign w_sof_ok   = (PATTERN_MODE == MODE_ABS_INC) ? (i_pac_chek_data == '0) : 1'b1;
   assign w_good_inc = (r_good == '1) ? r_good : r_good + CNT_W'(1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state plus the frame bookkeeping for the current word. w_fin_* is
   // the frame status including this word, or the status before it when a
   // sof truncates the running frame.
   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_adv        = 1'b0;
      w_done       = 1'b0;
      w_trunc      = 1'b0;
      w_orphan     = 1'b0;
      w_word_mis   = 1'b0;
      w_fin_len    = r_len;
      w_fin_good   = r_good;
      w_fin_err    = r_err;
      case (r_state)
         ST_IDLE: begin
            if (i_pac_chek_data_valid) begin
               if (i_pac_chek_sof) begin
                  w_word_mis = ~w_sof_ok;
                  if (i_pac_chek_eof) begin
                     w_done     = 1'b1;
                     w_fin_len  = 16'd1;
                     w_fin_good = w_sof_ok ? CNT_W'(1) : '0;
                     w_fin_err  = ~w_sof_ok;
                  end else begin
                     w_start      = 1'b1;
                     w_state_next = ST_IN_FRAME;
                  end
               end else begin
                  w_orphan = 1'b1;
               end
            end
         end
         ST_IN_FRAME: begin
            if (i_pac_chek_data_valid) begin
               if (i_pac_chek_sof) begin
                  // Running frame ends truncated; sof word opens a new one.
                  // A sof+eof here can only report one result, so the
                  // truncated frame is reported and the one-word frame dropped.
                  w_done     = 1'b1;
                  w_trunc    = 1'b1;
                  w_word_mis = ~w_sof_ok;
                  if (i_pac_chek_eof) begin
                     w_state_next = ST_IDLE;
                  end else begin
                     w_start = 1'b1;
                  end
               end else begin
                  w_adv      = 1'b1;
                  w_word_mis = (i_pac_chek_data != r_exp);
                  w_fin_len  = sat_inc16(r_len);
                  w_fin_good = w_word_mis ? r_good : w_good_inc;
                  w_fin_err  = r_err | w_word_mis;
                  if (i_pac_chek_eof) begin
                     w_done       = 1'b1;
                     w_state_next = ST_IDLE;
                  end
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
      w_fin_ok = w_done & ~w_trunc & ~w_fin_err & (w_fin_len == FRAME_LEN_VAL);
   end

   // Expected-word tracking and per-frame accumulation
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_exp  <= '0;
         r_len  <= '0;
         r_good <= '0;
         r_err  <= 1'b0;
      end else begin
         if (i_pac_chek_data_valid) begin
            // Seeded mode follows the received word (resyncs after an error);
            // absolute mode keeps counting from the frame start.
            if (PATTERN_MODE == MODE_SEED_INC) begin
               r_exp <= i_pac_chek_data + DATA_W'(1);
            end else if (i_pac_chek_sof) begin
               r_exp <= DATA_W'(1);
            end else begin
               r_exp <= r_exp + DATA_W'(1);
            end
         end
         if (w_start) begin
            r_len  <= 16'd1;
            r_good <= w_sof_ok ? CNT_W'(1) : '0;
            r_err  <= ~w_sof_ok;
         end else if (w_adv) begin
            r_len  <= w_fin_len;
            r_good <= w_fin_good;
            r_err  <= w_fin_err;
         end
      end
   end

   // Frame results, one cycle after the completing word; clear wins over
   // a coinciding update but the pulses are still produced.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_good_word_num  <= '0;
         r_last_frame_len <= '0;
         r_frame_done     <= 1'b0;
         r_frame_ok       <= 1'b0;
         r_err_sticky     <= 1'b0;
      end else begin
         r_frame_done <= w_done;
         r_frame_ok   <= w_fin_ok;
         if (i_clr) begin
            r_good_word_num  <= '0;
            r_last_frame_len <= '0;
            r_err_sticky     <= 1'b0;
         end else begin
            if (w_done) begin
               r_good_word_num  <= w_fin_good;
               r_last_frame_len <= w_fin_len;
            end
            if (w_orphan || (w_done && !w_fin_ok)) begin
               r_err_sticky <= 1'b1;
            end
         end
      end
   end

   assign w_cnt_inc[STAT_GOOD]   = w_fin_ok;
   assign w_cnt_inc[STAT_BAD]    = w_done & ~w_fin_ok;
   assign w_cnt_inc[STAT_ERR]    = w_word_mis;
   assign w_cnt_inc[STAT_ORPHAN] = w_orphan;

   genvar gi;
   generate
      for (gi = 0; gi < STAT_NUM; gi++) begin : g_stat
         sat_counter #(
            .W (CNT_W)
         ) u_cnt (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_inc   (w_cnt_inc[gi]),
            .i_clr   (i_clr),
            .o_cnt   (w_cnt[gi])
         );
      end
   endgenerate

   assign o_good_word_num  = r_good_word_num;
   assign o_last_frame_len = r_last_frame_len;
   assign o_frame_done     = r_frame_done;
   assign o_frame_ok       = r_frame_ok;
   assign o_good_frame_cnt = w_cnt[STAT_GOOD];
   assign o_bad_frame_cnt  = w_cnt[STAT_BAD];
   assign o_err_word_cnt   = w_cnt[STAT_ERR];
   assign o_orphan_cnt     = w_cnt[STAT_ORPHAN];
   assign o_err_sticky     = r_err_sticky;
   assign o_busy           = (r_state == ST_IN_FRAME);

endmodule

// File: tb/tb_pac_chek_multi.sv
// -----------------------------------------------------------------------------
// tb_pac_chek_multi
// Two checker instances (absolute and seeded mode) share the stream; only the
// instance selected by cur_mode receives valid words. A frame-level reference
// model collects each frame's words and judges it when it completes.
// -----------------------------------------------------------------------------
module tb_pac_chek_multi;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic        v0, v1;
   logic        sof, eof;
   logic [31:0] data;

   logic [31:0] good_num   [2];
   logic [15:0] last_len   [2];
   logic        frame_done [2];
   logic        frame_ok   [2];
   logic [31:0] good_cnt   [2];
   logic [31:0] bad_cnt    [2];
   logic [31:0] err_cnt    [2];
   logic [31:0] orph_cnt   [2];
   logic        sticky     [2];
   logic        busy       [2];

   int checks   = 0;
   int failures = 0;
   int cur_mode = 0;

   always #5 clk = ~clk;

   pac_chek_multi #(.DATA_W(32), .CNT_W(32), .FRAME_LEN_VAL(16'd200), .PATTERN_MODE(0)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
      .i_pac_chek_data(data), .i_pac_chek_data_valid(v0),
      .i_pac_chek_sof(sof), .i_pac_chek_eof(eof),
      .o_good_word_num(good_num[0]), .o_last_frame_len(last_len[0]),
      .o_frame_done(frame_done[0]), .o_frame_ok(frame_ok[0]),
      .o_good_frame_cnt(good_cnt[0]), .o_bad_frame_cnt(bad_cnt[0]),
      .o_err_word_cnt(err_cnt[0]), .o_orphan_cnt(orph_cnt[0]),
      .o_err_sticky(sticky[0]), .o_busy(busy[0]));

   pac_chek_multi #(.DATA_W(32), .CNT_W(32), .FRAME_LEN_VAL(16'd200), .PATTERN_MODE(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
      .i_pac_chek_data(data), .i_pac_chek_data_valid(v1),
      .i_pac_chek_sof(sof), .i_pac_chek_eof(eof),
      .o_good_word_num(good_num[1]), .o_last_frame_len(last_len[1]),
      .o_frame_done(frame_done[1]), .o_frame_ok(frame_ok[1]),
      .o_good_frame_cnt(good_cnt[1]), .o_bad_frame_cnt(bad_cnt[1]),
      .o_err_word_cnt(err_cnt[1]), .o_orphan_cnt(orph_cnt[1]),
      .o_err_sticky(sticky[1]), .o_busy(busy[1]));

   // Observed result pulses of the active instance
   int obs_done = 0, obs_ok = 0, obs_stray_ok = 0;
   always @(negedge clk) begin
      if (frame_done[cur_mode]) obs_done++;
      if (frame_ok[cur_mode]) obs_ok++;
      if (frame_ok[cur_mode] && !frame_done[cur_mode]) obs_stray_ok++;
   end

   // ---------------- reference model ----------------
   bit          m_in;
   logic [31:0] m_q[$];
   int          m_good, m_bad, m_err, m_orph, m_good_num, m_last_len;
   int          m_done_n = 0, m_ok_n = 0;
   bit          m_sticky;

   task automatic model_reset();
      m_in = 0; m_q = {};
      m_good = 0; m_bad = 0; m_err = 0; m_orph = 0;
      m_good_num = 0; m_last_len = 0; m_sticky = 0;
   endtask

   // Judge the collected frame from the pattern rules
   task automatic model_finish(input bit trunc);
      int len = m_q.size();
      int mis = 0;
      bit ok;
      for (int i = 0; i < len; i++) begin
         if (cur_mode == 0) begin
            if (m_q[i] !== 32'(i)) mis++;
         end else if (i > 0 && m_q[i] !== m_q[i-1] + 32'd1) begin
            mis++;
         end
      end
      ok = !trunc && mis == 0 && len == 200;
      m_done_n++;
      if (ok) begin m_ok_n++; m_good++; end
      else begin m_bad++; m_sticky = 1; end
      m_err += mis;
      m_good_num = len - mis;
      m_last_len = len;
   endtask

   task automatic model_word(input bit val, input bit s, input bit e,
                             input logic [31:0] d, input bit c);
      if (val) begin
         if (!m_in) begin
            if (s) begin
               m_q = {}; m_q.push_back(d);
               if (e) model_finish(0); else m_in = 1;
            end else begin
               m_orph++; m_sticky = 1;
            end
         end else if (s) begin
            model_finish(1);
            m_q = {}; m_q.push_back(d);
            if (e) begin m_in = 0; m_q = {}; end
         end else begin
            m_q.push_back(d);
            if (e) begin model_finish(0); m_in = 0; end
         end
      end
      if (c) begin
         m_good = 0; m_bad = 0; m_err = 0; m_orph = 0;
         m_good_num = 0; m_last_len = 0; m_sticky = 0;
      end
   endtask

   // ---------------- stimulus ----------------
   task automatic drive(input bit val, input bit s, input bit e,
                        input logic [31:0] d, input bit c);
      v0 = val && (cur_mode == 0); v1 = val && (cur_mode == 1);
      sof = s; eof = e; data = d; clr = c;
      @(posedge clk);
      model_word(val, s, e, d, c);
      @(negedge clk);
      v0 = 0; v1 = 0; sof = 0; eof = 0; clr = 0; data = $urandom;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 0);
   endtask

   // Words base+i; bad_idx is corrupted to 0xDEAD; drop_at removes words
   // drop_at and drop_at+1; optional random idle gaps between words.
   task automatic send_frame(input logic [31:0] base, input int n, input int bad_idx,
                             input int drop_at, input bit has_eof, input bit clr_eof);
      for (int i = 0; i < n; i++) begin
         if (drop_at >= 0 && (i == drop_at || i == drop_at + 1)) continue;
         drive(1, i == 0, has_eof && i == n - 1,
               (i == bad_idx) ? 32'hDEAD : base + 32'(i), clr_eof && i == n - 1);
         if ($urandom_range(0, 7) == 0) idle(1);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 0; clr = 0; v0 = 0; v1 = 0; sof = 0; eof = 0; data = '0;
      model_reset();
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({good_cnt[k], bad_cnt[k], err_cnt[k], orph_cnt[k], good_num[k]} !== '0) begin
            failures++; $display("FAIL reset_counters dut%0d actual good=%0d bad=%0d err=%0d orph=%0d num=%0d required 0",
                                 k, good_cnt[k], bad_cnt[k], err_cnt[k], orph_cnt[k], good_num[k]);
         end
         checks++;
         if ({last_len[k], frame_done[k], frame_ok[k], sticky[k], busy[k]} !== '0) begin
            failures++; $display("FAIL reset_flags dut%0d actual len=%0d done=%b ok=%b sticky=%b busy=%b required 0",
                                 k, last_len[k], frame_done[k], frame_ok[k], sticky[k], busy[k]);
         end
      end
      rst_n = 1;
      idle(2);
   endtask

   task automatic test_clean_frames();
      int ok0;
      cur_mode = 0; drive(0, 0, 0, 0, 1);
      ok0 = obs_ok;
      for (int f = 0; f < 3; f++) begin send_frame(0, 200, -1, -1, 1, 0); idle($urandom_range(0, 3)); end
      idle(2);
      checks++; if (good_cnt[0] !== 32'd3) begin failures++; $display("FAIL clean_good_cnt actual=%0d required=3", good_cnt[0]); end
      checks++; if (good_num[0] !== 32'd200) begin failures++; $display("FAIL clean_good_num actual=%0d required=200", good_num[0]); end
      checks++; if (obs_ok - ok0 != 3) begin failures++; $display("FAIL clean_ok_pulses actual=%0d required=3", obs_ok - ok0); end
      checks++; if (sticky[0] !== 1'b0) begin failures++; $display("FAIL clean_sticky actual=%b required=0", sticky[0]); end
      checks++; if (last_len[0] !== 16'(m_last_len)) begin failures++; $display("FAIL clean_len actual=%0d required=%0d", last_len[0], m_last_len); end
   endtask

   task automatic test_corrupt_word();
      cur_mode = 0; drive(0, 0, 0, 0, 1);
      send_frame(0, 200, 50, -1, 1, 0);
      idle(2);
      checks++; if (err_cnt[0] !== 32'(m_err) || m_err != 1) begin failures++; $display("FAIL corrupt_err actual=%0d required=%0d", err_cnt[0], m_err); end
      checks++; if (good_num[0] !== 32'd199) begin failures++; $display("FAIL corrupt_good_num actual=%0d required=199", good_num[0]); end
      checks++; if (bad_cnt[0] !== 32'd1) begin failures++; $display("FAIL corrupt_bad actual=%0d required=1", bad_cnt[0]); end
      checks++; if (sticky[0] !== 1'b1) begin failures++; $display("FAIL corrupt_sticky actual=%b required=1", sticky[0]); end
   endtask

   task automatic test_seed_drop();
      cur_mode = 1; drive(0, 0, 0, 0, 1);
      send_frame(32'h1000, 200, -1, $urandom_range(20, 170), 1, 0);
      idle(2);
      checks++; if (err_cnt[1] !== 32'd1) begin failures++; $display("FAIL seed_err actual=%0d required=1", err_cnt[1]); end
      checks++; if (last_len[1] !== 16'd198) begin failures++; $display("FAIL seed_len actual=%0d required=198", last_len[1]); end
      checks++; if (bad_cnt[1] !== 32'd1) begin failures++; $display("FAIL seed_bad actual=%0d required=1", bad_cnt[1]); end
      checks++; if (good_num[1] !== 32'(m_good_num)) begin failures++; $display("FAIL seed_good_num actual=%0d required=%0d", good_num[1], m_good_num); end
   endtask

   task automatic test_truncate();
      cur_mode = 0; drive(0, 0, 0, 0, 1);
      send_frame(0, 120, -1, -1, 0, 0);
      checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL trunc_busy actual=%b required=1", busy[0]); end
      send_frame(0, 200, -1, -1, 1, 0);
      idle(2);
      checks++; if (bad_cnt[0] !== 32'd1) begin failures++; $display("FAIL trunc_bad actual=%0d required=1", bad_cnt[0]); end
      checks++; if (good_cnt[0] !== 32'd1) begin failures++; $display("FAIL trunc_good actual=%0d required=1", good_cnt[0]); end
      checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL trunc_idle actual=%b required=0", busy[0]); end
   endtask

   task automatic test_orphan();
      cur_mode = 0; drive(0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) drive(1, 0, 1'($urandom_range(0, 1)), $urandom, 0);
      drive(1, 1, 1, 32'd0, 0);
      idle(2);
      checks++; if (orph_cnt[0] !== 32'd5) begin failures++; $display("FAIL orphan_cnt actual=%0d required=5", orph_cnt[0]); end
      checks++; if (last_len[0] !== 16'd1) begin failures++; $display("FAIL orphan_len actual=%0d required=1", last_len[0]); end
      checks++; if (bad_cnt[0] !== 32'd1 || good_cnt[0] !== 32'd0) begin failures++; $display("FAIL orphan_frame actual bad=%0d good=%0d required bad=1 good=0", bad_cnt[0], good_cnt[0]); end
      checks++; if (sticky[0] !== 1'b1) begin failures++; $display("FAIL orphan_sticky actual=%b required=1", sticky[0]); end
   endtask

   task automatic test_clr_and_reset();
      int d0, k0;
      cur_mode = 0;
      d0 = obs_done; k0 = obs_ok;
      send_frame(0, 200, -1, -1, 1, 1);   // clear on the completing word
      idle(2);
      checks++; if ({good_cnt[0], bad_cnt[0], orph_cnt[0], good_num[0]} !== '0 || last_len[0] !== 16'd0 || sticky[0] !== 1'b0) begin
         failures++; $display("FAIL clr_coincide actual good=%0d bad=%0d orph=%0d num=%0d len=%0d sticky=%b required 0",
                              good_cnt[0], bad_cnt[0], orph_cnt[0], good_num[0], last_len[0], sticky[0]);
      end
      checks++; if (obs_done - d0 != 1 || obs_ok - k0 != 1) begin failures++; $display("FAIL clr_pulses actual done=%0d ok=%0d required 1 1", obs_done - d0, obs_ok - k0); end
      // Reset in the middle of a frame
      send_frame(0, 80, -1, -1, 0, 0);
      checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL midrst_busy actual=%b required=1", busy[0]); end
      rst_n = 0; model_reset();
      @(negedge clk);
      checks++; if (busy[0] !== 1'b0 || frame_done[0] !== 1'b0 || last_len[0] !== 16'd0) begin
         failures++; $display("FAIL midrst_state actual busy=%b done=%b len=%0d required 0", busy[0], frame_done[0], last_len[0]);
      end
      rst_n = 1;
      idle(2);
      send_frame(0, 200, -1, -1, 1, 0);
      idle(2);
      checks++; if (good_cnt[0] !== 32'd1 || bad_cnt[0] !== 32'd0) begin failures++; $display("FAIL midrst_after actual good=%0d bad=%0d required 1 0", good_cnt[0], bad_cnt[0]); end
   endtask

   task automatic test_random();
      for (int m = 0; m < 2; m++) begin
         cur_mode = m; drive(0, 0, 0, 0, 1);
         for (int f = 0; f < 6; f++) begin
            send_frame((m == 0) ? 32'd0 : $urandom, 199 + $urandom_range(0, 2),
                       ($urandom_range(0, 1) == 1) ? $urandom_range(1, 198) : -1,
                       -1, 1, 0);
            idle($urandom_range(0, 2));
         end
         idle(2);
         checks++; if (good_cnt[m] !== 32'(m_good)) begin failures++; $display("FAIL rand%0d_good actual=%0d required=%0d", m, good_cnt[m], m_good); end
         checks++; if (bad_cnt[m] !== 32'(m_bad)) begin failures++; $display("FAIL rand%0d_bad actual=%0d required=%0d", m, bad_cnt[m], m_bad); end
         checks++; if (err_cnt[m] !== 32'(m_err)) begin failures++; $display("FAIL rand%0d_err actual=%0d required=%0d", m, err_cnt[m], m_err); end
         checks++; if (good_num[m] !== 32'(m_good_num) || last_len[m] !== 16'(m_last_len)) begin
            failures++; $display("FAIL rand%0d_last actual num=%0d len=%0d required num=%0d len=%0d", m, good_num[m], last_len[m], m_good_num, m_last_len);
         end
         checks++; if (sticky[m] !== m_sticky) begin failures++; $display("FAIL rand%0d_sticky actual=%b required=%b", m, sticky[m], m_sticky); end
      end
   endtask

   initial begin
      test_reset();
      test_clean_frames();
      test_corrupt_word();
      test_seed_drop();
      test_truncate();
      test_orphan();
      test_clr_and_reset();
      test_random();
      idle(2);
      checks++; if (obs_done != m_done_n || obs_ok != m_ok_n) begin
         failures++; $display("FAIL pulse_totals actual done=%0d ok=%0d required done=%0d ok=%0d", obs_done, obs_ok, m_done_n, m_ok_n);
      end
      checks++; if (obs_stray_ok != 0) begin failures++; $display("FAIL ok_without_done actual=%0d required=0", obs_stray_ok); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
